// File: rtl/pe_feed_ctrl.sv
// pe_feed_ctrl
//   Master-side driver for one processing element. Takes a MAC job (length K,
//   bias), streams K ifmap/filter pairs into the PE and drives mult_seln and
//   acc_seln. Once the PE has finished, it merges the PE's two accumulator
//   phases with the bias and returns one 2*DATA_WIDTH result.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              job request (accepted only when idle)
//   i_cfg_len            K, number of products
//   i_cfg_bias           bias added to the final sum
//   o_busy               job in flight
//   i_op_valid/o_op_ready, i_op_ifmap/i_op_fltr    operand pair stream
//   o_pe_ifmap/o_pe_fltr/o_pe_psum_m2p             master-to-PE data
//   i_pe_psum_p2m        combinational MAC output of the PE
//   o_mult_seln          1 = PE adds product, 0 = PE adds o_pe_psum_m2p
//   o_acc_seln           1 = PE accumulator phase register cleared
//   o_res_valid/i_res_ready/o_res_data             result handshake
module pe_feed_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MULT_LAT   = 2,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [LEN_WIDTH-1:0]    i_cfg_len,
   input  logic [2*DATA_WIDTH-1:0] i_cfg_bias,
   output logic                    o_busy,
   input  logic                    i_op_valid,
   output logic                    o_op_ready,
   input  logic [DATA_WIDTH-1:0]   i_op_ifmap,
   input  logic [DATA_WIDTH-1:0]   i_op_fltr,
   output logic [DATA_WIDTH-1:0]   o_pe_ifmap,
   output logic [DATA_WIDTH-1:0]   o_pe_fltr,
   output logic [2*DATA_WIDTH-1:0] o_pe_psum_m2p,
   input  logic [2*DATA_WIDTH-1:0] i_pe_psum_p2m,
   output logic                    o_mult_seln,
   output logic                    o_acc_seln,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [2*DATA_WIDTH-1:0] o_res_data
);

   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned TW = MULT_LAT + 1;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StDrain,
      StMerge,
      StOut
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_issued;
   logic [PW-1:0]         r_bias;
   logic [PW-1:0]         r_p0;
   logic [PW-1:0]         r_res;
   logic [DATA_WIDTH-1:0] r_pe_ifmap;
   logic [DATA_WIDTH-1:0] r_pe_fltr;
   // Bit i set: the tagged pair's product reaches the PE adder i cycles from now
   // counted backwards from MULT_LAT; the top bit marks the arrival cycle itself.
   logic [TW-1:0]         r_tag_first;
   logic [TW-1:0]         r_tag_last;
   logic                  r_acc_clr;

   logic w_start_acc;
   logic w_len_zero;
   logic w_op_ready;
   logic w_op_hs;
   logic w_first_pair;
   logic w_last_pair;
   logic w_arrive_first;
   logic w_arrive_last;

   assign w_start_acc    = i_start && (r_state == StIdle);
   assign w_len_zero     = (i_cfg_len == '0);
   assign w_op_ready     = (r_state == StIssue) && (r_issued < r_len);
   assign w_op_hs        = w_op_ready && i_op_valid;
   assign w_first_pair   = w_op_hs && (r_issued == '0);
   assign w_last_pair    = w_op_hs && (r_issued == (r_len - LEN_WIDTH'(1)));
   assign w_arrive_first = r_tag_first[MULT_LAT];
   assign w_arrive_last  = r_tag_last[MULT_LAT];

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_nxt = w_len_zero ? StOut : StIssue;
            end
         end
         StIssue: begin
            if (w_last_pair) begin
               w_state_nxt = StDrain;
            end
         end
         StDrain: begin
            if (w_arrive_last) begin
               w_state_nxt = StMerge;
            end
         end
         StMerge: begin
            w_state_nxt = StOut;
         end
         StOut: begin
            if (i_res_ready) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_len       <= '0;
         r_issued    <= '0;
         r_bias      <= '0;
         r_p0        <= '0;
         r_res       <= '0;
         r_pe_ifmap  <= '0;
         r_pe_fltr   <= '0;
         r_tag_first <= '0;
         r_tag_last  <= '0;
         r_acc_clr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_start_acc) begin
            r_len    <= i_cfg_len;
            r_bias   <= i_cfg_bias;
            r_issued <= '0;
         end else if (w_op_hs) begin
            r_issued <= r_issued + LEN_WIDTH'(1);
         end

         // Non-handshake cycles present zeros so the PE accumulates zero products.
         r_pe_ifmap <= w_op_hs ? i_op_ifmap : '0;
         r_pe_fltr  <= w_op_hs ? i_op_fltr  : '0;

         r_tag_first <= (r_tag_first << 1) | TW'(w_first_pair);
         r_tag_last  <= (r_tag_last << 1)  | TW'(w_last_pair);

         // Hold both accumulator phases cleared until the first real product lands.
         if (w_start_acc && !w_len_zero) begin
            r_acc_clr <= 1'b1;
         end else if (w_arrive_first) begin
            r_acc_clr <= 1'b0;
         end

         // Phase A total is the MAC output in the last product's arrival cycle.
         if ((r_state == StDrain) && w_arrive_last) begin
            r_p0 <= i_pe_psum_p2m;
         end

         // In MERGE the PE returns phase B + bias, so the sum is the full result.
         if (w_start_acc && w_len_zero) begin
            r_res <= i_cfg_bias;
         end else if (r_state == StMerge) begin
            r_res <= r_p0 + i_pe_psum_p2m;
         end
      end
   end

   assign o_busy        = (r_state != StIdle);
   assign o_op_ready    = w_op_ready;
   assign o_pe_ifmap    = r_pe_ifmap;
   assign o_pe_fltr     = r_pe_fltr;
   assign o_pe_psum_m2p = r_bias;
   assign o_mult_seln   = (r_state != StMerge);
   assign o_acc_seln    = r_acc_clr;
   assign o_res_valid   = (r_state == StOut);
   assign o_res_data    = r_res;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// tb_pe_feed_ctrl
//   Bench for pe_feed_ctrl with a behavioural two-phase PE (MULT_LAT = 2).
//   Expected results are bias + sum of products (mod 2^32); expected latency is
//   K + MULT_LAT + 3 plus the operand stall cycles the bench inserts.
module tb_pe_feed_ctrl;

   localparam int ML = 2;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] cfg_len;
   logic [31:0] cfg_bias;
   logic        busy;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_ifmap;
   logic [15:0] op_fltr;
   logic [15:0] pe_ifmap;
   logic [15:0] pe_fltr;
   logic [31:0] pe_m2p;
   logic [31:0] pe_p2m;
   logic        mult_seln;
   logic        acc_seln;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;

   int errors = 0;
   int checks = 0;

   logic [15:0] ifm [16];
   logic [15:0] flt [16];

   pe_feed_ctrl #(
      .DATA_WIDTH (16),
      .MULT_LAT   (ML),
      .LEN_WIDTH  (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_cfg_len     (cfg_len),
      .i_cfg_bias    (cfg_bias),
      .o_busy        (busy),
      .i_op_valid    (op_valid),
      .o_op_ready    (op_ready),
      .i_op_ifmap    (op_ifmap),
      .i_op_fltr     (op_fltr),
      .o_pe_ifmap    (pe_ifmap),
      .o_pe_fltr     (pe_fltr),
      .o_pe_psum_m2p (pe_m2p),
      .i_pe_psum_p2m (pe_p2m),
      .o_mult_seln   (mult_seln),
      .o_acc_seln    (acc_seln),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_data    (res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE: 2-stage multiplier, two alternating accumulator phases.
   logic [31:0] pe_p1;
   logic [31:0] pe_p2;
   logic [31:0] pe_acc [2];
   logic        pe_ph;

   assign pe_p2m = (mult_seln ? pe_p2 : pe_m2p) + (acc_seln ? 32'd0 : pe_acc[pe_ph]);

   always @(posedge clk) begin
      if (rst) begin
         pe_p1     <= 32'd0;
         pe_p2     <= 32'd0;
         pe_acc[0] <= 32'd0;
         pe_acc[1] <= 32'd0;
         pe_ph     <= 1'b0;
      end else begin
         pe_p1         <= 32'(pe_ifmap) * 32'(pe_fltr);
         pe_p2         <= pe_p1;
         pe_acc[pe_ph] <= pe_p2m;
         pe_ph         <= ~pe_ph;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_op_ready"}, 32'(op_ready), 32'd0);
      check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_res_data"}, res_data, 32'd0);
      check({tag, "_pe_ifmap"}, 32'(pe_ifmap), 32'd0);
      check({tag, "_pe_fltr"}, 32'(pe_fltr), 32'd0);
      check({tag, "_pe_m2p"}, pe_m2p, 32'd0);
      check({tag, "_mult_seln"}, 32'(mult_seln), 32'd1);
      check({tag, "_acc_seln"}, 32'(acc_seln), 32'd0);
   endtask

   // mode 0: op_valid always high; 1: stall st_len cycles before pair st_at;
   // 2: random stalls. Result is held rdy_delay cycles before res_ready.
   // poke drives start during backpressure and in the handshake cycle.
   task automatic run_job(input string tag, input int k, input logic [31:0] bias,
                          input int mode, input int st_at, input int st_len,
                          input int rdy_delay, input bit poke);
      int          idx;
      int          stalls;
      int          pre;
      int          stalled;
      int          rel;
      int          accn;
      int          exp_lat;
      bit          v;
      bit          hs;
      bit          timed_out;
      logic [31:0] expv;

      expv = bias;
      for (int i = 0; i < k; i++) begin
         expv = expv + 32'(ifm[i]) * 32'(flt[i]);
      end

      start    = 1'b1;
      cfg_len  = 16'(k);
      cfg_bias = bias;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cfg_len  = 16'd0;
      cfg_bias = $urandom;
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);

      idx = 0; stalls = 0; pre = 0; stalled = 0; rel = 1; accn = 0; timed_out = 0;
      while (res_valid !== 1'b1) begin
         if (rel > 300) begin
            timed_out = 1;
            break;
         end
         if (acc_seln === 1'b1) accn++;
         if (idx < k) begin
            if (mode == 1) v = !((idx == st_at) && (stalled < st_len));
            else if (mode == 2) v = ($urandom_range(0, 2) != 0);
            else v = 1'b1;
            if (!v) begin
               stalls++;
               if (idx == st_at) stalled++;
               if (idx == 0) pre++;
            end
         end else begin
            v = 1'b0;
         end
         op_valid = v;
         op_ifmap = v ? ifm[idx] : 16'($urandom);
         op_fltr  = v ? flt[idx] : 16'($urandom);
         hs = v && (op_ready === 1'b1);
         @(posedge clk);
         #1;
         if (hs) idx++;
         rel++;
      end
      op_valid = 1'b0;

      if (timed_out) begin
         checks++;
         errors++;
         $error("FAIL %s_timeout: observed no res_valid within %0d cycles expected res_valid",
                tag, rel);
         return;
      end

      exp_lat = (k == 0) ? 1 : k + ML + 3 + stalls;
      check({tag, "_latency"}, 32'(rel), 32'(exp_lat));
      check({tag, "_res_data"}, res_data, expv);
      check({tag, "_acc_cycles"}, 32'(accn), (k == 0) ? 32'd0 : 32'(4 + pre));

      for (int i = 0; i < rdy_delay; i++) begin
         if (poke && (i == 0)) begin
            start    = 1'b1;
            cfg_len  = 16'd3;
            cfg_bias = 32'h1234_5678;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         check({tag, "_bp_valid"}, 32'(res_valid), 32'd1);
         check({tag, "_bp_data"}, res_data, expv);
         check({tag, "_bp_busy"}, 32'(busy), 32'd1);
      end

      res_ready = 1'b1;
      if (poke) begin
         start    = 1'b1;
         cfg_len  = 16'd0;
         cfg_bias = 32'd77;
      end
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      start     = 1'b0;
      check({tag, "_post_valid"}, 32'(res_valid), 32'd0);
      check({tag, "_post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int          seen;
      int          k;
      logic [31:0] b;

      rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_bias = '0;
      op_valid = 1'b0; op_ifmap = '0; op_fltr = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Basic job: 1*4 + 2*5 + 3*6 + 10 = 42
      ifm[0] = 16'd1; ifm[1] = 16'd2; ifm[2] = 16'd3;
      flt[0] = 16'd4; flt[1] = 16'd5; flt[2] = 16'd6;
      run_job("basic", 3, 32'd10, 0, 0, 0, 0, 0);
      // Two-cycle stall between first and second pair
      run_job("stall", 3, 32'd10, 1, 1, 2, 0, 0);

      ifm[0] = 16'd7; flt[0] = 16'd8;
      run_job("k1", 1, 32'd0, 0, 0, 0, 0, 0);
      run_job("k0", 0, 32'd5, 0, 0, 0, 0, 0);

      // Backpressure with ignored starts, then a job right after the handshake
      ifm[0] = 16'd1; ifm[1] = 16'd2; ifm[2] = 16'd3;
      flt[0] = 16'd4; flt[1] = 16'd5; flt[2] = 16'd6;
      run_job("bp", 3, 32'd10, 0, 0, 0, 5, 1);
      ifm[0] = 16'd1; flt[0] = 16'd1;
      run_job("wrap", 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

      // Reset during ISSUE
      for (int i = 0; i < 4; i++) begin
         ifm[i] = 16'($urandom);
         flt[i] = 16'($urandom);
      end
      start = 1'b1; cfg_len = 16'd4; cfg_bias = 32'd99;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_valid = 1'b1; op_ifmap = ifm[0]; op_fltr = flt[0];
      @(posedge clk);
      #1;
      op_ifmap = ifm[1]; op_fltr = flt[1];
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("abort");
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (res_valid !== 1'b0) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);

      ifm[0] = 16'd3; flt[0] = 16'd3; ifm[1] = 16'd2; flt[1] = 16'd2;
      run_job("after_rst", 2, 32'd0, 0, 0, 0, 0, 0);

      // Randomized jobs against the arithmetic model
      for (int j = 0; j < 20; j++) begin
         k = $urandom_range(0, 8);
         b = $urandom;
         for (int i = 0; i < k; i++) begin
            ifm[i] = 16'($urandom);
            flt[i] = 16'($urandom);
         end
         run_job("rand", k, b, 2, 0, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
